mul_seq: RTL and testbench

- Iterative shift-add multiply sequencer for the multicycle ARM core. It handles MUL, MLA, UMULL and SMULL.
- The main decode FSM hands over operands with a start pulse, waits on busy, then commits one or two register write-backs.
- The sequencer drives those write-backs as wr_en/wr_hi so that long multiplies write RdLo then RdHi on consecutive cycles.
- Sits beside the ALU; the result is muxed into the Result path by the datapath.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_shift_add.sv | 59 +++++
 rtl/mul_seq.sv | 147 ++++++++++++++
 tb/tb_mul_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared encodings for the iterative multiply sequencer
//
// Purpose: operation encodings, sequencer state enum and the iteration
// counter width helper used by mul_seq and mul_shift_add.
// Ports: none (package).
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MLA   = 2'b01,
        OP_UMULL = 2'b10,
        OP_SMULL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        NEG,
        ACC,
        WBLO,
        WBHI
    } state_e;

    // One extra bit so the counter can hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - 2W product register with shift-add, negate and accumulate steps
//
// Purpose: datapath of the multiply sequencer. The multiplier is parked in
// the low half of the product register and consumed from bit 0 as the
// partial sum shifts in from the top, so after WIDTH steps the register
// holds the full 2W product.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   load              capture multiplicand, multiplier and addend; clear upper half
//   step              one shift-add iteration
//   neg               replace product with its two's complement
//   acc_en            low half += latched addend (modulo 2^W)
//   mcand, mplier     operand magnitudes sampled on load
//   addend            MLA addend sampled on load
//   product           current 2W product register
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 neg,
    input  logic                 acc_en,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] addend_r;
    logic [WIDTH:0]   sum;

    // Carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum = {1'b0, product[2*WIDTH-1:WIDTH]}
            + (product[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product  <= '0;
            mcand_r  <= '0;
            addend_r <= '0;
        end else if (load) begin
            product  <= {{WIDTH{1'b0}}, mplier};
            mcand_r  <= mcand;
            addend_r <= addend;
        end else if (step) begin
            product <= {sum, product[WIDTH-1:1]};
        end else if (neg) begin
            product <= -product;
        end else if (acc_en) begin
            product[WIDTH-1:0] <= product[WIDTH-1:0] + addend_r;
        end
    end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative MUL/MLA/UMULL/SMULL sequencer with register write-back strobes
//
// Purpose: accepts operands on a start pulse, runs WIDTH shift-add
// iterations, optionally negates (SMULL) or accumulates (MLA), then issues
// one write-back (RdLo/Rd) or two (RdLo then RdHi) for long multiplies.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, op         request pulse and operation, accepted only in IDLE
//   a, b, acc         multiplicand, multiplier, MLA addend (sampled at accept)
//   flush             abandon the in-flight operation
//   busy, long_op     sequencer active / active on a long multiply
//   wr_en, wr_hi      write strobe and RdHi qualifier
//   result            data for the current write-back
//   done              pulse on the final write-back
//   flag_n, flag_z    sign / zero of the final result, valid with done
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic             flush,
    output logic             busy,
    output logic             wr_en,
    output logic             wr_hi,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             long_op,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int CW = cnt_width(WIDTH);

    state_e              state, state_next;
    op_e                 op_r;
    logic                neg_r;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  product;

    logic                accept;
    logic                is_smull_in;
    logic                is_long;
    logic                last;
    logic                load, step, neg_en, acc_en;
    logic [WIDTH-1:0]    a_mag, b_mag;

    assign is_smull_in = (op_e'(op) == OP_SMULL);
    assign accept      = (state == IDLE) && start && !flush;
    assign is_long     = (op_r == OP_UMULL) || (op_r == OP_SMULL);

    assign a_mag = (is_smull_in && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_smull_in && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_r  <= OP_MUL;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_r <= op_e'(op);
                // A zero operand yields a zero product, which needs no NEG pass.
                neg_r <= is_smull_in && (a[WIDTH-1] ^ b[WIDTH-1]) && (|a) && (|b);
                cnt   <= CW'(WIDTH);
            end else if (state == ITER) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign last = (cnt == CW'(1));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        neg_en     = 1'b0;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = ITER;
                end
            end
            ITER: begin
                step = 1'b1;
                if (last) begin
                    if (op_r == OP_SMULL && neg_r) state_next = NEG;
                    else if (op_r == OP_MLA)       state_next = ACC;
                    else                           state_next = WBLO;
                end
            end
            NEG: begin
                neg_en     = 1'b1;
                state_next = WBLO;
            end
            ACC: begin
                acc_en     = 1'b1;
                state_next = WBLO;
            end
            WBLO: state_next = is_long ? WBHI : IDLE;
            WBHI: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush && state != IDLE) begin
            state_next = IDLE;
            step       = 1'b0;
            neg_en     = 1'b0;
            acc_en     = 1'b0;
        end

        busy    = (state != IDLE);
        long_op = busy && is_long;
        wr_hi   = (state == WBHI);
        wr_en   = ((state == WBLO) || (state == WBHI)) && !flush;
        done    = (((state == WBLO) && !is_long) || (state == WBHI)) && !flush;
        result  = '0;
        if (state == WBLO) result = product[WIDTH-1:0];
        if (state == WBHI) result = product[2*WIDTH-1:WIDTH];
        flag_n  = done && (is_long ? product[2*WIDTH-1] : product[WIDTH-1]);
        flag_z  = done && (is_long ? (product == '0) : (product[WIDTH-1:0] == '0));
    end

    mul_shift_add #(.WIDTH(WIDTH)) u_shift_add (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .neg     (neg_en),
        .acc_en  (acc_en),
        .mcand   (a_mag),
        .mplier  (b_mag),
        .addend  (acc),
        .product (product)
    );

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b, acc;
    logic        busy, wr_en, wr_hi, done, long_op, flag_n, flag_z;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    // Per-run capture of up to two write-backs.
    int          nwr;
    int          busy_low;
    logic        lop1;
    int          wc [2];
    logic        wh [2];
    logic [31:0] wres [2];
    logic        wd [2];
    logic        wfn [2];
    logic        wfz [2];

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .acc     (acc),
        .flush   (flush),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_hi   (wr_hi),
        .result  (result),
        .done    (done),
        .long_op (long_op),
        .flag_n  (flag_n),
        .flag_z  (flag_z)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start an op at the current sample point (cycle 0) and capture writes.
    // s_cyc/f_cyc/r_cyc inject start/flush/reset in that cycle (0 = none).
    task automatic run(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] iacc, input int s_cyc, input int f_cyc, input int r_cyc);
        start = 1'b1; op = o; a = ia; b = ib; acc = iacc;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; acc = $urandom;
        nwr = 0; busy_low = -1; lop1 = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            start = (k == s_cyc);
            if (start) begin op = 2'b00; a = 32'd100; b = 32'd100; end
            flush = (k == f_cyc);
            reset = (k == r_cyc);
            #1;
            if (k == 1) lop1 = long_op;
            if (!busy) begin
                busy_low = k;
                break;
            end
            if (wr_en) begin
                if (nwr < 2) begin
                    wc[nwr] = k; wh[nwr] = wr_hi; wres[nwr] = result;
                    wd[nwr] = done; wfn[nwr] = flag_n; wfz[nwr] = flag_z;
                end
                nwr++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        a = '0; b = '0; acc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {56'd0, busy, wr_en, wr_hi, done, long_op, flag_n, flag_z, 1'b0}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MUL 7*6 with a stray start at cycle 10 and at the done cycle.
        run(2'b00, 32'd7, 32'd6, 32'd0, 10, 0, 0);
        chk("mul_nwr", 64'(nwr), 64'd1);
        chk("mul_cyc", 64'(wc[0]), 64'd33);
        chk("mul_lo", {31'd0, wh[0], wres[0]}, {32'd0, 32'd42});
        chk("mul_flags", {61'd0, wd[0], wfn[0], wfz[0]}, 64'b100);
        chk("mul_busylow", 64'(busy_low), 64'd34);
        chk("mul_longop", {63'd0, lop1}, 64'd0);

        // Start coincident with done is not accepted.
        run(2'b00, 32'd7, 32'd6, 32'd0, 33, 0, 0);
        chk("mul_done_start_busylow", 64'(busy_low), 64'd34);

        // MUL with bit 31 set in the truncated result.
        run(2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0, 0);
        chk("mul_neg_lo", {32'd0, wres[0]}, {32'd0, 32'hFFFF_FFFE});
        chk("mul_neg_flags", {62'd0, wfn[0], wfz[0]}, 64'b10);

        // MLA 3*4+5
        run(2'b01, 32'd3, 32'd4, 32'd5, 0, 0, 0);
        chk("mla_nwr", 64'(nwr), 64'd1);
        chk("mla_cyc", 64'(wc[0]), 64'd34);
        chk("mla_res", {31'd0, wd[0], wres[0]}, {31'd0, 1'b1, 32'd17});

        // UMULL max*max
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
        chk("umull_nwr", 64'(nwr), 64'd2);
        chk("umull_lo", {wc[0][7:0], 22'd0, wh[0], wd[0], wres[0]}, {8'd33, 22'd0, 2'b00, 32'h0000_0001});
        chk("umull_hi", {wc[1][7:0], 22'd0, wh[1], wd[1], wres[1]}, {8'd34, 22'd0, 2'b11, 32'hFFFF_FFFE});
        chk("umull_flags", {62'd0, wfn[1], wfz[1]}, 64'b10);
        chk("umull_longop", {63'd0, lop1}, 64'd1);

        // SMULL -2*3 = -6
        run(2'b11, 32'hFFFF_FFFE, 32'd3, 32'd0, 0, 0, 0);
        chk("smull_nwr", 64'(nwr), 64'd2);
        chk("smull_lo", {wc[0][7:0], 22'd0, wh[0], wd[0], wres[0]}, {8'd34, 22'd0, 2'b00, 32'hFFFF_FFFA});
        chk("smull_hi", {wc[1][7:0], 22'd0, wh[1], wd[1], wres[1]}, {8'd35, 22'd0, 2'b11, 32'hFFFF_FFFF});
        chk("smull_flags", {62'd0, wfn[1], wfz[1]}, 64'b10);

        // SMULL 0*-5 = 0: no negate pass
        run(2'b11, 32'd0, 32'hFFFF_FFFB, 32'd0, 0, 0, 0);
        chk("smull0_lo", {wc[0][7:0], 24'd0, wres[0]}, {8'd33, 24'd0, 32'd0});
        chk("smull0_hi", {wc[1][7:0], 23'd0, wd[1], wres[1]}, {8'd34, 23'd0, 1'b1, 32'd0});
        chk("smull0_flags", {62'd0, wfn[1], wfz[1]}, 64'b01);

        // Flush at cycle 10 of a MUL, then a new MUL starting at cycle 11.
        run(2'b00, 32'd5, 32'd5, 32'd0, 0, 10, 0);
        chk("flush_nwr", 64'(nwr), 64'd0);
        chk("flush_busylow", 64'(busy_low), 64'd11);
        run(2'b00, 32'd12, 32'd11, 32'd0, 0, 0, 0);
        chk("post_flush_res", {24'd0, wc[0][7:0], wres[0]}, {24'd0, 8'd33, 32'd132});

        // Reset during ITER of a UMULL.
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 5);
        chk("rst_mid_nwr", 64'(nwr), 64'd0);
        chk("rst_mid_busylow", 64'(busy_low), 64'd6);
        chk("rst_mid_outs", {24'd0, busy, wr_en, wr_hi, done, long_op, flag_n, flag_z, 1'b0, result},
            64'd0);

        // MUL 0*9 after the reset.
        run(2'b00, 32'd0, 32'd9, 32'd0, 0, 0, 0);
        chk("mul0_res", {32'd0, wres[0]}, 64'd0);
        chk("mul0_flags", {61'd0, wd[0], wfn[0], wfz[0]}, 64'b101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
